// File: rtl/rs485_port_mux_pkg.sv
// Shared types for the RS-485 port mux: channel modes, per-channel FSM states, transceiver pin triple.
package rs485_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_TX   = 2'd1,
        MODE_RX   = 2'd2,
        MODE_AUTO = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_SAFE,
        ST_IDLE_OFF,
        ST_TX,
        ST_RX,
        ST_LEAD,
        ST_LAG,
        ST_TURN
    } ch_state_e;

    typedef struct packed {
        logic d;
        logic n_re;
        logic de;
    } pins_t;

    localparam pins_t SAFE_PINS = '{d: 1'b0, n_re: 1'b1, de: 1'b0};

    // Timer width for the longest of the three timed states, never narrower than one bit.
    function automatic int cnt_width(input int lead, input int lag, input int turn);
        int m;
        m = lead;
        if (lag > m)  m = lag;
        if (turn > m) m = turn;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rs485_port_mux_ch_fsm.sv
// One transceiver channel: pending config, mode/src registers, half-duplex FSM and registered pins.
// Pins and busy are registered from the next state, so they line up with the state register.
module rs485_ch_fsm
    import rs485_pkg::*;
#(
    parameter int SRC_W = 2,
    parameter int LEAD  = 4,
    parameter int LAG   = 4,
    parameter int TURN  = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [1:0]       wr_mode,
    input  logic [SRC_W-1:0] wr_src,
    input  logic             line,
    input  logic             active,
    output logic [SRC_W-1:0] sel_src,
    output logic             d,
    output logic             n_re,
    output logic             de,
    output logic             busy,
    output logic             rx_en_nxt
);

    localparam logic [CNT_W-1:0] TURN_LOAD = (TURN > 0) ? CNT_W'(TURN - 1) : '0;
    localparam logic [CNT_W-1:0] LAG_LOAD  = (LAG > 0)  ? CNT_W'(LAG - 1)  : TURN_LOAD;
    localparam logic [CNT_W-1:0] LEAD_LOAD = (LEAD > 0) ? CNT_W'(LEAD - 1) : '0;
    localparam ch_state_e TURN_ENTRY = (TURN > 0) ? ST_TURN : ST_RX;
    localparam ch_state_e LAG_ENTRY  = (LAG > 0)  ? ST_LAG  : TURN_ENTRY;
    localparam ch_state_e LEAD_ENTRY = (LEAD > 0) ? ST_LEAD : ST_TX;

    logic             pend_vld;
    mode_e            pend_mode;
    logic [SRC_W-1:0] pend_src;
    mode_e            mode, mode_nxt;
    logic [SRC_W-1:0] src, src_nxt;
    ch_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    pins_t            pins_q, pins_nxt;
    logic             busy_q, busy_nxt;

    function automatic ch_state_e home(input mode_e m);
        case (m)
            MODE_TX:   return ST_TX;
            MODE_RX:   return ST_RX;
            MODE_AUTO: return ST_RX;
            default:   return ST_IDLE_OFF;
        endcase
    endfunction

    always_comb begin
        mode_nxt  = mode;
        src_nxt   = src;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (pend_vld) begin
            mode_nxt  = pend_mode;
            src_nxt   = pend_src;
            state_nxt = (TURN > 0) ? ST_SAFE : home(pend_mode);
            cnt_nxt   = TURN_LOAD;
        end else begin
            case (state)
                ST_SAFE: begin
                    if (cnt == '0) state_nxt = home(mode);
                    else           cnt_nxt   = cnt - 1'b1;
                end
                ST_RX: begin
                    if (mode == MODE_AUTO && active) begin
                        state_nxt = LEAD_ENTRY;
                        cnt_nxt   = LEAD_LOAD;
                    end
                end
                ST_TX: begin
                    if (mode == MODE_AUTO && !active) begin
                        state_nxt = LAG_ENTRY;
                        cnt_nxt   = LAG_LOAD;
                    end
                end
                ST_LEAD: begin
                    // Source dropping out mid-preamble still gets the full LAG/TURN tail.
                    if (!active) begin
                        state_nxt = LAG_ENTRY;
                        cnt_nxt   = LAG_LOAD;
                    end else if (cnt == '0) begin
                        state_nxt = ST_TX;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_LAG: begin
                    if (cnt == '0) begin
                        state_nxt = TURN_ENTRY;
                        cnt_nxt   = TURN_LOAD;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_TURN: begin
                    if (cnt == '0) state_nxt = ST_RX;
                    else           cnt_nxt   = cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pins_nxt = SAFE_PINS;
        case (state_nxt)
            ST_TX:            pins_nxt = '{d: line, n_re: 1'b1, de: 1'b1};
            ST_RX:            pins_nxt = '{d: 1'b0, n_re: 1'b0, de: 1'b0};
            ST_LEAD, ST_LAG:  pins_nxt = '{d: 1'b1, n_re: 1'b1, de: 1'b1};
            default:          pins_nxt = SAFE_PINS;
        endcase
        busy_nxt  = state_nxt inside {ST_SAFE, ST_LEAD, ST_LAG, ST_TURN};
        rx_en_nxt = (state_nxt == ST_RX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_mode <= MODE_OFF;
            pend_src  <= '0;
            mode      <= MODE_OFF;
            src       <= '0;
            state     <= ST_SAFE;
            cnt       <= '0;
            pins_q    <= SAFE_PINS;
            busy_q    <= 1'b0;
        end else begin
            pend_vld <= wr;
            if (wr) begin
                pend_mode <= mode_e'(wr_mode);
                pend_src  <= wr_src;
            end
            mode   <= mode_nxt;
            src    <= src_nxt;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            pins_q <= pins_nxt;
            busy_q <= busy_nxt;
        end
    end

    assign sel_src = src_nxt;
    assign d       = pins_q.d;
    assign n_re    = pins_q.n_re;
    assign de      = pins_q.de;
    assign busy    = busy_q;

endmodule

// File: rtl/rs485_port_mux.sv
// Runtime routing of HSI serial sources onto N_CH RS-485 transceivers with per-channel half-duplex control.
// rx_q returns, per source, the R line of the lowest-index channel currently receiving for it (idle 1).
module rs485_port_mux
    import rs485_pkg::*;
#(
    parameter int N_CH  = 22,
    parameter int N_SRC = 4,
    parameter int LEAD  = 4,
    parameter int LAG   = 4,
    parameter int TURN  = 8,
    parameter int CH_W  = $clog2(N_CH),
    parameter int SRC_W = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [SRC_W-1:0] cfg_src,
    input  logic [N_SRC-1:0] src_line,
    input  logic [N_SRC-1:0] src_active,
    input  logic [N_CH-1:0]  rx_pin,
    output logic [N_CH-1:0]  d_pin,
    output logic [N_CH-1:0]  n_re_pin,
    output logic [N_CH-1:0]  de_pin,
    output logic [N_SRC-1:0] rx_q,
    output logic [N_CH-1:0]  busy
);

    localparam int CNT_W = cnt_width(LEAD, LAG, TURN);

    logic [SRC_W-1:0] sel_src [N_CH];
    logic [N_CH-1:0]  rx_en;
    logic [N_SRC-1:0] rx_nxt;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (cfg_ch == CH_W'(c));

        rs485_ch_fsm #(
            .SRC_W (SRC_W),
            .LEAD  (LEAD),
            .LAG   (LAG),
            .TURN  (TURN),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr        (wr),
            .wr_mode   (cfg_mode),
            .wr_src    (cfg_src),
            .line      (src_line[sel_src[c]]),
            .active    (src_active[sel_src[c]]),
            .sel_src   (sel_src[c]),
            .d         (d_pin[c]),
            .n_re      (n_re_pin[c]),
            .de        (de_pin[c]),
            .busy      (busy[c]),
            .rx_en_nxt (rx_en[c])
        );
    end

    // Scan high-to-low so the lowest-index receiving channel wins.
    always_comb begin
        rx_nxt = '1;
        for (int s = 0; s < N_SRC; s++) begin
            for (int c = N_CH - 1; c >= 0; c--) begin
                if (rx_en[c] && sel_src[c] == SRC_W'(s)) rx_nxt[s] = rx_pin[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rx_q <= '1;
        else     rx_q <= rx_nxt;
    end

endmodule
